// File: rtl/sram_dump.sv
// SRAM readback engine: streams a header, a byte range and an optional checksum out of an 8N1 UART.
// Optional feature: define SRAM_DUMP_CHECKSUM_EN to append a two's-complement checksum byte.
module sram_dump #(
    parameter int unsigned CLKS_PER_BIT = 35,
    parameter int unsigned RD_LAT       = 1
) (
    input  logic        clock4,
    input  logic        reset,
    input  logic        start,
    input  logic [18:0] base,
    input  logic [18:0] count,
    output logic        busy,
    output logic        done,
    output logic [18:0] ram_address,
    output logic        ram_load,
    input  logic [7:0]  ram_data,
    output logic        UART_TX
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned RD_W  = $clog2(RD_LAT + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_READ,
        ST_SEND
`ifdef SRAM_DUMP_CHECKSUM_EN
        , ST_CSUM
`endif
    } state_t;

    state_t             state_q, state_d;
    logic [63:0]        hdr_sr_q, hdr_sr_d;
    logic [3:0]         hdr_idx_q, hdr_idx_d;
    logic [18:0]        addr_q, addr_d;
    logic [18:0]        remaining_q, remaining_d;
    logic [RD_W-1:0]    rd_cnt_q, rd_cnt_d;
    logic [8:0]         sh_q, sh_d;
    logic [3:0]         bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0]   clk_cnt_q, clk_cnt_d;
    logic               tx_act_q, tx_act_d;
    logic               busy_d, done_d, ram_load_d, uart_tx_d;
    logic [18:0]        ram_address_d;
`ifdef SRAM_DUMP_CHECKSUM_EN
    logic [7:0]         csum_q, csum_d;
`endif

    logic               tx_last;
    logic               tx_load;
    logic [7:0]         tx_byte;
    logic               finish;

    // Sequencer and serialiser next-state logic
    always_comb begin
        state_d       = state_q;
        hdr_sr_d      = hdr_sr_q;
        hdr_idx_d     = hdr_idx_q;
        addr_d        = addr_q;
        remaining_d   = remaining_q;
        rd_cnt_d      = rd_cnt_q;
        sh_d          = sh_q;
        bit_cnt_d     = bit_cnt_q;
        clk_cnt_d     = clk_cnt_q;
        tx_act_d      = tx_act_q;
        busy_d        = busy;
        done_d        = 1'b0;
        ram_load_d    = ram_load;
        ram_address_d = ram_address;
        uart_tx_d     = UART_TX;
`ifdef SRAM_DUMP_CHECKSUM_EN
        csum_d        = csum_q;
`endif
        tx_load       = 1'b0;
        tx_byte       = 8'h00;
        finish        = 1'b0;
        tx_last       = tx_act_q && (clk_cnt_q == CNT_W'(CLKS_PER_BIT - 1)) && (bit_cnt_q == 4'd9);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_HDR;
                    hdr_sr_d    = {13'h0000, base, 13'h0000, count};
                    hdr_idx_d   = 4'd0;
                    addr_d      = base;
                    remaining_d = count;
`ifdef SRAM_DUMP_CHECKSUM_EN
                    csum_d      = 8'h00;
`endif
                end
            end
            ST_HDR: begin
                if (hdr_idx_q != 4'd8) begin
                    if (!tx_act_q || tx_last) begin
                        tx_load   = 1'b1;
                        tx_byte   = hdr_sr_q[63:56];
                        hdr_sr_d  = {hdr_sr_q[55:0], 8'h00};
                        hdr_idx_d = hdr_idx_q + 4'd1;
                    end
                end else if (tx_last) begin
                    if (remaining_q == 19'd0) begin
                        finish = 1'b1;
                    end else begin
                        state_d       = ST_READ;
                        ram_load_d    = 1'b1;
                        ram_address_d = addr_q;
                        rd_cnt_d      = RD_W'(0);
                    end
                end
            end
            ST_READ: begin
                if (rd_cnt_q == RD_W'(RD_LAT - 1)) begin
                    ram_load_d  = 1'b0;
                    tx_load     = 1'b1;
                    tx_byte     = ram_data;
                    addr_d      = addr_q + 19'd1;
                    remaining_d = remaining_q - 19'd1;
`ifdef SRAM_DUMP_CHECKSUM_EN
                    csum_d      = csum_q + ram_data;
`endif
                    state_d     = ST_SEND;
                end else begin
                    rd_cnt_d = rd_cnt_q + RD_W'(1);
                end
            end
            ST_SEND: begin
                if (tx_last) begin
                    if (remaining_q != 19'd0) begin
                        state_d       = ST_READ;
                        ram_load_d    = 1'b1;
                        ram_address_d = addr_q;
                        rd_cnt_d      = RD_W'(0);
                    end else begin
                        finish = 1'b1;
                    end
                end
            end
`ifdef SRAM_DUMP_CHECKSUM_EN
            ST_CSUM: begin
                if (tx_last) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        if (finish) begin
`ifdef SRAM_DUMP_CHECKSUM_EN
            state_d = ST_CSUM;
            tx_load = 1'b1;
            tx_byte = 8'h00 - csum_q;
`else
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
`endif
        end

        // A load replaces the final stop-bit cycle so bytes run back to back
        if (tx_load) begin
            uart_tx_d = 1'b0;
            sh_d      = {1'b1, tx_byte};
            bit_cnt_d = 4'd0;
            clk_cnt_d = CNT_W'(0);
            tx_act_d  = 1'b1;
            busy_d    = 1'b1;
        end else if (tx_act_q) begin
            if (clk_cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
                clk_cnt_d = CNT_W'(0);
                if (bit_cnt_q == 4'd9) begin
                    tx_act_d = 1'b0;
                end else begin
                    uart_tx_d = sh_q[0];
                    sh_d      = {1'b1, sh_q[8:1]};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end
            end else begin
                clk_cnt_d = clk_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock4 or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            hdr_sr_q    <= 64'h0;
            hdr_idx_q   <= 4'd0;
            addr_q      <= 19'd0;
            remaining_q <= 19'd0;
            rd_cnt_q    <= RD_W'(0);
            sh_q        <= 9'h1FF;
            bit_cnt_q   <= 4'd0;
            clk_cnt_q   <= CNT_W'(0);
            tx_act_q    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            ram_load    <= 1'b0;
            ram_address <= 19'd0;
            UART_TX     <= 1'b1;
`ifdef SRAM_DUMP_CHECKSUM_EN
            csum_q      <= 8'h00;
`endif
        end else begin
            state_q     <= state_d;
            hdr_sr_q    <= hdr_sr_d;
            hdr_idx_q   <= hdr_idx_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            rd_cnt_q    <= rd_cnt_d;
            sh_q        <= sh_d;
            bit_cnt_q   <= bit_cnt_d;
            clk_cnt_q   <= clk_cnt_d;
            tx_act_q    <= tx_act_d;
            busy        <= busy_d;
            done        <= done_d;
            ram_load    <= ram_load_d;
            ram_address <= ram_address_d;
            UART_TX     <= uart_tx_d;
`ifdef SRAM_DUMP_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

endmodule

// File: tb/tb_sram_dump.sv
// Directed bench for sram_dump: table of dumps decoded from UART_TX plus reset and mid-dump start corners.
module tb_sram_dump;

    localparam int CPB = 4;

    logic        clock4 = 1'b0;
    logic        reset;
    logic        start;
    logic [18:0] base, count;
    logic        sel;

    logic        busy1, done1, load1, tx1;
    logic [18:0] addr1;
    logic [7:0]  data1;
    logic        busy3, done3, load3, tx3;
    logic [18:0] addr3;
    logic [7:0]  data3;

    logic        busy_m, done_m, load_m, tx_m;
    logic [18:0] addr_m;

    int errors = 0;
    int checks = 0;

    always #5 clock4 = ~clock4;

    function automatic logic [7:0] mem_f(input logic [18:0] a);
        case (a)
            19'h00010: return 8'hA5;
            19'h00011: return 8'h3C;
            19'h00012: return 8'hFF;
            default:   return a[7:0] ^ 8'h5A;
        endcase
    endfunction

    assign data1  = mem_f(addr1);
    assign data3  = mem_f(addr3);
    assign busy_m = sel ? busy3 : busy1;
    assign done_m = sel ? done3 : done1;
    assign load_m = sel ? load3 : load1;
    assign tx_m   = sel ? tx3   : tx1;
    assign addr_m = sel ? addr3 : addr1;

    sram_dump #(.CLKS_PER_BIT(CPB), .RD_LAT(1)) dut (
        .clock4(clock4), .reset(reset), .start(start & ~sel), .base(base), .count(count),
        .busy(busy1), .done(done1), .ram_address(addr1), .ram_load(load1),
        .ram_data(data1), .UART_TX(tx1)
    );

    sram_dump #(.CLKS_PER_BIT(CPB), .RD_LAT(3)) dut3 (
        .clock4(clock4), .reset(reset), .start(start & sel), .base(base), .count(count),
        .busy(busy3), .done(done3), .ram_address(addr3), .ram_load(load3),
        .ram_data(data3), .UART_TX(tx3)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic [18:0]          base;
        logic [18:0]          count;
        logic                 sel;
        logic                 inject;
        logic [0:10][7:0]     exp;
        logic [7:0]           csum;
        logic [0:2][18:0]     addrs;
    } vec_t;

    vec_t vecs[5];

    task automatic run_dump(input vec_t v);
        logic q[$];
        logic [18:0] seen[$];
        int   rdl, cyc, run, pos, gap, n, dones, exp_len;
        logic prev_load, sb, st, wok, bitv;
        logic [7:0] bv, ev;
        rdl = v.sel ? 3 : 1;
        sel = v.sel;
        @(negedge clock4);
        base = v.base; count = v.count; start = 1'b1;
        @(negedge clock4);
        start = 1'b0;
        chk("busy_before_first_bit", {31'd0, busy_m}, 32'd0);
        @(negedge clock4);
        chk("first_start_bit", {30'd0, busy_m, tx_m}, 32'h2);
        cyc = 0; run = 0; prev_load = 1'b0; dones = 0;
        while (busy_m && cyc < 3000) begin
            q.push_back(tx_m);
            if (done_m) dones++;
            if (load_m && !prev_load) seen.push_back(addr_m);
            if (load_m) run++;
            if (!load_m && prev_load) begin
                chk("ram_load_run", run, rdl);
                run = 0;
            end
            prev_load = load_m;
            if (v.inject && cyc == 30) begin base = 19'h0; count = 19'h5; start = 1'b1; end
            if (v.inject && cyc == 31) start = 1'b0;
            cyc++;
            @(negedge clock4);
        end
        chk("dump_terminates", {31'd0, busy_m}, 32'd0);
        chk("done_at_busy_fall", {31'd0, done_m}, 32'd1);
        chk("load_low_at_end", {31'd0, load_m}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clock4);
            if (done_m) dones++;
        end
        chk("done_single_pulse", dones, 0);
        chk("ram_address_holds", addr_m, (v.count == 0) ? addr_m : v.addrs[v.count - 1]);
        chk("load_count", seen.size(), v.count);
        for (int i = 0; i < seen.size() && i < 3; i++)
            chk($sformatf("ram_address_%0d", i), seen[i], v.addrs[i]);
        n = 8 + int'(v.count);
`ifdef SRAM_DUMP_CHECKSUM_EN
        n++;
`endif
        exp_len = n * 10 * CPB + int'(v.count) * rdl;
        chk("busy_length", q.size(), exp_len);
        pos = 0;
        for (int k = 0; k < n; k++) begin
            gap = 0;
            while (pos < q.size() && q[pos] == 1'b1) begin gap++; pos++; end
            chk($sformatf("gap_%0d", k), gap, (k >= 8 && k < 8 + int'(v.count)) ? rdl : 0);
            bv = 8'h00; wok = 1'b1; sb = 1'b1; st = 1'b0;
            for (int bi = 0; bi < 10; bi++) begin
                bitv = (pos < q.size()) ? q[pos] : 1'bx;
                for (int j = 0; j < CPB; j++)
                    if (pos + j >= q.size() || q[pos + j] !== bitv) wok = 1'b0;
                if (bi == 0) sb = bitv;
                else if (bi == 9) st = bitv;
                else bv[bi - 1] = bitv;
                pos += CPB;
            end
            ev = (k < 8 + int'(v.count)) ? v.exp[k] : v.csum;
            chk($sformatf("byte_%0d", k), {21'd0, sb, st, wok, bv}, {21'd0, 1'b0, 1'b1, 1'b1, ev});
        end
    endtask

    initial begin
        logic seen_done;
        int   waited;
        vecs[0] = '{base: 19'h00010, count: 19'd3, sel: 1'b0, inject: 1'b0,
                    exp: {8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h03, 8'hA5, 8'h3C, 8'hFF},
                    csum: 8'h20, addrs: {19'h00010, 19'h00011, 19'h00012}};
        vecs[1] = '{base: 19'h7FFFF, count: 19'd0, sel: 1'b0, inject: 1'b0,
                    exp: {8'h00, 8'h07, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                    csum: 8'h00, addrs: {19'h0, 19'h0, 19'h0}};
        vecs[2] = '{base: 19'h7FFFE, count: 19'd3, sel: 1'b0, inject: 1'b0,
                    exp: {8'h00, 8'h07, 8'hFF, 8'hFE, 8'h00, 8'h00, 8'h00, 8'h03, 8'hA4, 8'hA5, 8'h5A},
                    csum: 8'h5D, addrs: {19'h7FFFE, 19'h7FFFF, 19'h00000}};
        vecs[3] = '{base: 19'h00123, count: 19'd2, sel: 1'b1, inject: 1'b0,
                    exp: {8'h00, 8'h00, 8'h01, 8'h23, 8'h00, 8'h00, 8'h00, 8'h02, 8'h79, 8'h7E, 8'h00},
                    csum: 8'h09, addrs: {19'h00123, 19'h00124, 19'h0}};
        vecs[4] = vecs[0];
        vecs[4].inject = 1'b1;

        reset = 1'b1; start = 1'b0; base = '0; count = '0; sel = 1'b0;
        repeat (3) @(negedge clock4);
        chk("reset_state", {9'd0, busy1, done1, load1, tx1, addr1}, {9'd0, 4'b0001, 19'd0});
        reset = 1'b0;
        repeat (2) @(negedge clock4);

        for (int i = 0; i < 5; i++) run_dump(vecs[i]);

        // Abort mid-dump while a read strobe is active
        sel = 1'b0;
        @(negedge clock4);
        base = 19'h00010; count = 19'd3; start = 1'b1;
        @(negedge clock4);
        start = 1'b0;
        waited = 0;
        while (!load1 && waited < 1000) begin @(negedge clock4); waited++; end
        chk("reach_read_before_reset", {31'd0, load1}, 32'd1);
        #1 reset = 1'b1;
        #1 chk("reset_abort", {29'd0, tx1, busy1, load1}, 32'h4);
        seen_done = 1'b0;
        repeat (3) begin @(negedge clock4); if (done1) seen_done = 1'b1; end
        reset = 1'b0;
        repeat (20) begin @(negedge clock4); if (done1) seen_done = 1'b1; end
        chk("no_done_after_abort", {31'd0, seen_done}, 32'd0);
        chk("idle_after_abort", {30'd0, busy1, tx1}, 32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
